// File: rtl/parking_occupancy_core.sv
// Purpose: 4-slot parking occupancy tracker with door timer, full warning and display clock dividers.
// Latency: sensor/switch sampled at E0 affect parking_slots/door_open_light at E2; capacity/best_place/full_light are combinational.
// Backpressure: none; sensors are free-running levels and every qualifying rising edge is acted on immediately.

module parking_occupancy_core #(
   parameter int unsigned DOOR_CYCLES = 40_000_000,
   parameter int unsigned HALF_100HZ  = 200_000,
   parameter int unsigned HALF_2HZ    = 10_000_000,
   parameter int unsigned HALF_1HZ    = 20_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       entry_sensor,
   input  logic       exit_sensor,
   input  logic [1:0] switch,
   output logic [3:0] parking_slots,
   output logic       door_open_light,
   output logic       full_light,
   output logic [2:0] capacity,
   output logic [2:0] best_place,
   output logic       clk_100hz,
   output logic       clk_2hz,
   output logic       clk_1hz
);

   localparam int unsigned DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES + 1) : 1;

   logic       entry_s1, entry_s2, entry_prev;
   logic       exit_s1, exit_s2, exit_prev;
   logic [1:0] switch_s1, switch_s2;
   logic       entry_rise, exit_rise;
   logic [3:0] slots_after_exit, slots_next;
   logic       grant;
   logic [DW-1:0] door_cnt;

   // Two-flop synchronizers plus previous-value flops for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_s1   <= 1'b0;
         entry_s2   <= 1'b0;
         entry_prev <= 1'b0;
         exit_s1    <= 1'b0;
         exit_s2    <= 1'b0;
         exit_prev  <= 1'b0;
         switch_s1  <= 2'd0;
         switch_s2  <= 2'd0;
      end else begin
         entry_s1   <= entry_sensor;
         entry_s2   <= entry_s1;
         entry_prev <= entry_s2;
         exit_s1    <= exit_sensor;
         exit_s2    <= exit_s1;
         exit_prev  <= exit_s2;
         switch_s1  <= switch;
         switch_s2  <= switch_s1;
      end
   end

   assign entry_rise = entry_s2 & ~entry_prev;
   assign exit_rise  = exit_s2 & ~exit_prev;

   // Exit is resolved first so a simultaneous entry can reuse the slot just freed.
   always_comb begin
      slots_after_exit = parking_slots;
      grant            = 1'b0;
      if (exit_rise && parking_slots[switch_s2]) begin
         slots_after_exit[switch_s2] = 1'b0;
         grant                       = 1'b1;
      end
      slots_next = slots_after_exit;
      if (entry_rise) begin
         if (!slots_after_exit[0]) begin
            slots_next[0] = 1'b1;
            grant         = 1'b1;
         end else if (!slots_after_exit[1]) begin
            slots_next[1] = 1'b1;
            grant         = 1'b1;
         end else if (!slots_after_exit[2]) begin
            slots_next[2] = 1'b1;
            grant         = 1'b1;
         end else if (!slots_after_exit[3]) begin
            slots_next[3] = 1'b1;
            grant         = 1'b1;
         end
      end
   end

   // Occupancy register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parking_slots <= 4'b0000;
      end else begin
         parking_slots <= slots_next;
      end
   end

   // Door timer: every grant reloads the full interval, otherwise count down to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         door_cnt <= '0;
      end else if (grant) begin
         door_cnt <= DW'(DOOR_CYCLES);
      end else if (door_cnt != '0) begin
         door_cnt <= door_cnt - DW'(1);
      end
   end

   assign door_open_light = (door_cnt != '0);

   // Free slots = 4 minus the number of occupied bits.
   always_comb begin
      capacity = 3'd4 - ({2'b00, parking_slots[0]} + {2'b00, parking_slots[1]}
                       + {2'b00, parking_slots[2]} + {2'b00, parking_slots[3]});
   end

   // Lowest free slot, reported 1-based; zero means no slot is free.
   always_comb begin
      best_place = 3'd0;
      if (!parking_slots[0])      best_place = 3'd1;
      else if (!parking_slots[1]) best_place = 3'd2;
      else if (!parking_slots[2]) best_place = 3'd3;
      else if (!parking_slots[3]) best_place = 3'd4;
   end

   // Raw pins on purpose: the warning lamp reacts as soon as the car is seen.
   assign full_light = (parking_slots == 4'b1111) & entry_sensor & ~exit_sensor;

   clk_divider #(.HALF(HALF_100HZ)) u_div_100hz (.clk(clk), .rst_n(rst_n), .clk_out(clk_100hz));
   clk_divider #(.HALF(HALF_2HZ))   u_div_2hz   (.clk(clk), .rst_n(rst_n), .clk_out(clk_2hz));
   clk_divider #(.HALF(HALF_1HZ))   u_div_1hz   (.clk(clk), .rst_n(rst_n), .clk_out(clk_1hz));

endmodule

// Purpose: square-wave divider toggling every HALF clk cycles.
// Latency: first toggle on the HALF-th rising edge after reset release.
// Backpressure: none; free-running.
module clk_divider #(
   parameter int unsigned HALF = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic clk_out
);

   localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;

   logic [CW-1:0] cnt;

   // Count to HALF-1, then wrap and flip the output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         clk_out <= 1'b0;
      end else if (cnt == CW'(HALF - 1)) begin
         cnt     <= '0;
         clk_out <= ~clk_out;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_parking_occupancy_core.sv
// Randomized and directed stimulus for parking_occupancy_core against a history-based reference model.
// Every cycle all outputs are compared after the falling edge.
// Reset is applied at start and again mid-run to confirm the asynchronous clear.

module tb_parking_occupancy_core;

   localparam int DOOR = 4;
   localparam int H100 = 3;
   localparam int H2   = 5;
   localparam int H1   = 10;
   localparam int HMAX = 8192;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       entry_sensor;
   logic       exit_sensor;
   logic [1:0] switch;
   logic [3:0] parking_slots;
   logic       door_open_light;
   logic       full_light;
   logic [2:0] capacity;
   logic [2:0] best_place;
   logic       clk_100hz;
   logic       clk_2hz;
   logic       clk_1hz;

   parking_occupancy_core #(
      .DOOR_CYCLES(DOOR),
      .HALF_100HZ (H100),
      .HALF_2HZ   (H2),
      .HALF_1HZ   (H1)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .entry_sensor   (entry_sensor),
      .exit_sensor    (exit_sensor),
      .switch         (switch),
      .parking_slots  (parking_slots),
      .door_open_light(door_open_light),
      .full_light     (full_light),
      .capacity       (capacity),
      .best_place     (best_place),
      .clk_100hz      (clk_100hz),
      .clk_2hz        (clk_2hz),
      .clk_1hz        (clk_1hz)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: rising-edge count since reset release, occupancy, door deadline.
   int       m;
   int       door_until;
   bit [3:0] ms;
   bit       ent_h [HMAX];
   bit       ex_h  [HMAX];
   bit [1:0] sw_h  [HMAX];

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s at m=%0d: got %0d expected %0d", tag, m, obs, exp);
      end
   endtask

   function automatic bit he(input int i);
      return (i >= 1) ? ent_h[i] : 1'b0;
   endfunction

   function automatic bit hx(input int i);
      return (i >= 1) ? ex_h[i] : 1'b0;
   endfunction

   function automatic bit [1:0] hs(input int i);
      return (i >= 1) ? sw_h[i] : 2'd0;
   endfunction

   task automatic check_all();
      int free_cnt;
      int best;
      free_cnt = 0;
      best     = 0;
      for (int i = 3; i >= 0; i--) begin
         if (!ms[i]) begin
            free_cnt++;
            best = i + 1;
         end
      end
      chk("slots",    int'(parking_slots),   int'(ms));
      chk("capacity", int'(capacity),        free_cnt);
      chk("best",     int'(best_place),      best);
      chk("door",     int'(door_open_light), (m < door_until) ? 1 : 0);
      chk("full",     int'(full_light),      (ms == 4'hF && entry_sensor && !exit_sensor) ? 1 : 0);
      chk("clk100",   int'(clk_100hz),       (m / H100) % 2);
      chk("clk2",     int'(clk_2hz),         (m / H2) % 2);
      chk("clk1",     int'(clk_1hz),         (m / H1) % 2);
   endtask

   // A sensor level seen at edge k-2 that was low at k-3 acts at edge k.
   task automatic model_step();
      bit       er;
      bit       xr;
      bit [1:0] sw;
      bit       g;
      er = he(m - 2) & ~he(m - 3);
      xr = hx(m - 2) & ~hx(m - 3);
      sw = hs(m - 2);
      g  = 1'b0;
      if (xr && ms[sw]) begin
         ms[sw] = 1'b0;
         g      = 1'b1;
      end
      if (er) begin
         for (int i = 0; i < 4; i++) begin
            if (!ms[i]) begin
               ms[i] = 1'b1;
               g     = 1'b1;
               break;
            end
         end
      end
      if (g) door_until = m + DOOR;
   endtask

   // Entered and left at a falling edge: drive inputs, step one rising edge, compare.
   task automatic cyc(input bit e, input bit x, input bit [1:0] sw);
      if (m + 1 >= HMAX) begin
         $display("FAIL cycle_budget: got %0d expected below %0d", m + 1, HMAX);
         $fatal(1);
      end
      entry_sensor  = e;
      exit_sensor   = x;
      switch        = sw;
      ent_h[m + 1]  = e;
      ex_h[m + 1]   = x;
      sw_h[m + 1]   = sw;
      @(posedge clk);
      m++;
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic pulse(input bit e, input bit x, input bit [1:0] sw);
      cyc(e, x, sw);
      cyc(e, x, sw);
      repeat (6) cyc(1'b0, 1'b0, sw);
   endtask

   task automatic check_reset_values();
      chk("rst_slots",  int'(parking_slots),   0);
      chk("rst_cap",    int'(capacity),        4);
      chk("rst_best",   int'(best_place),      1);
      chk("rst_door",   int'(door_open_light), 0);
      chk("rst_full",   int'(full_light),      0);
      chk("rst_clk100", int'(clk_100hz),       0);
      chk("rst_clk2",   int'(clk_2hz),         0);
      chk("rst_clk1",   int'(clk_1hz),         0);
   endtask

   task automatic model_reset();
      m          = 0;
      door_until = 0;
      ms         = 4'b0000;
   endtask

   initial begin
      rst_n        = 1'b0;
      entry_sensor = 1'b0;
      exit_sensor  = 1'b0;
      switch       = 2'd0;
      model_reset();
      #2;
      check_reset_values();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_all();

      // Fill the lot one car at a time.
      repeat (4) pulse(1'b1, 1'b0, 2'd0);

      // Full lot with entry held: warning lamp only, no allocation.
      repeat (5) cyc(1'b1, 1'b0, 2'd0);
      repeat (3) cyc(1'b0, 1'b0, 2'd0);

      // Vacate slot 2, then try vacating it again.
      pulse(1'b0, 1'b1, 2'd2);
      pulse(1'b0, 1'b1, 2'd2);
      pulse(1'b1, 1'b0, 2'd0);

      // Simultaneous exit of slot 1 and entry on a full lot.
      pulse(1'b1, 1'b1, 2'd1);

      // Free two slots, then hold entry high for 20 cycles.
      pulse(1'b0, 1'b1, 2'd0);
      pulse(1'b0, 1'b1, 2'd3);
      repeat (20) cyc(1'b1, 1'b0, 2'd0);
      repeat (4) cyc(1'b0, 1'b0, 2'd0);

      // Door retrigger: two entry edges two cycles apart.
      pulse(1'b0, 1'b1, 2'd1);
      pulse(1'b0, 1'b1, 2'd2);
      cyc(1'b1, 1'b0, 2'd0);
      cyc(1'b0, 1'b0, 2'd0);
      cyc(1'b1, 1'b0, 2'd0);
      repeat (8) cyc(1'b0, 1'b0, 2'd0);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
      end

      // Asynchronous reset in the middle of a cycle.
      pulse(1'b1, 1'b0, 2'd0);
      cyc(1'b1, 1'b0, 2'd0);
      entry_sensor = 1'b0;
      exit_sensor  = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      check_all();

      // Dividers from a clean start, then more random traffic.
      repeat (45) cyc(1'b0, 1'b0, 2'd0);
      for (int i = 0; i < 300; i++) begin
         cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/parking_occupancy_core.md
# parking_occupancy_core

Occupancy controller for a 4-slot parking lot. It debounce-free synchronizes the entry/exit sensors and the 2-bit slot-select switch, tracks per-slot occupancy, and reports free capacity, the best free slot, a timed door-open indication and a full warning. It also divides the system clock into the 100 Hz, 2 Hz and 1 Hz clocks used by the display and indicator logic. It sits between the board inputs and the seven-segment display driver.

## Interface
Parameters:
- DOOR_CYCLES, 40_000_000: number of clk cycles door_open_light stays high after a granted entry or exit (≥1).
- HALF_100HZ, 200_000: clk cycles per half-period of clk_100hz.
- HALF_2HZ, 10_000_000: clk cycles per half-period of clk_2hz.
- HALF_1HZ, 20_000_000: clk cycles per half-period of clk_1hz.

Ports:
- clk  in  1  system clock (40 MHz nominal); one clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- entry_sensor  in  1  car at entrance (asynchronous level).
- exit_sensor  in  1  car at exit (asynchronous level).
- switch  in  2  slot index (0–3) being vacated on exit.
- parking_slots  out  4  occupancy bitmap, bit i = slot i occupied.
- door_open_light  out  1  door open indication.
- full_light  out  1  entry attempted while lot full.
- capacity  out  3  number of free slots, 0–4.
- best_place  out  3  lowest free slot index + 1 (1–4); 0 when full.
- clk_100hz, clk_2hz, clk_1hz  out  1 each  divided square-wave clocks.

## Operation
- entry_sensor, exit_sensor and switch each pass through a 2-flop synchronizer; entry/exit then go through a rising-edge detector (sync2 & ~prev). Only rising edges act; holding a sensor high does nothing further.
- Exit edge: if parking_slots[switch] = 1, clear that bit and grant. If the slot is already free, ignore (no door).
- Entry edge: if any slot free, set the lowest-index free bit and grant. If full, ignore (no door).
- Simultaneous entry and exit edges in the same cycle: exit is applied first, then entry allocates the lowest free slot of the post-exit map (so a full lot with a valid exit still admits the car).
- Grant (entry or exit) loads door counter with DOOR_CYCLES; door_open_light = (counter ≠ 0); counter decrements each cycle; a new grant restarts it.
- capacity = 4 − popcount(parking_slots), combinational.
- best_place: combinational priority encode of lowest zero bit, +1; 3'd0 when all four occupied.
- full_light = (parking_slots == 4'b1111) & entry_sensor & ~exit_sensor, combinational on raw sensor pins (no synchronizer).
- Dividers: independent counters; each output toggles when its counter reaches HALF_x − 1, counter then wraps to 0. 50% duty, period 2·HALF_x clk cycles.

## Timing
- Reset (rst_n low, immediate): parking_slots = 0, capacity = 4, best_place = 1, door_open_light = 0, door counter 0, all synchronizer/edge flops 0, divider counters 0, clk_100hz/clk_2hz/clk_1hz = 0.
- Sensor/switch sampled high at rising edge E0: sync2 at E1, parking_slots/door_open_light update at E2; capacity/best_place follow combinationally in the same cycle.
- switch must be stable from E0 through E1 of the exit edge.
- door_open_light high for exactly DOOR_CYCLES cycles starting at E2.
- First divider output toggle at edge number HALF_x after reset release (counting from 1).
- Reset mid-operation clears occupancy and aborts any door interval.

## Test plan
- Reset, then 4 entry pulses (DOOR_CYCLES=4): parking_slots 0001→0011→0111→1111; capacity 3,2,1,0; best_place 2,3,4,0; door high 4 cycles after each.
- Lot full, entry held high, exit low: parking_slots stays 1111, no door, full_light = 1; drop entry → full_light = 0.
- Map 1111, switch=2, exit pulse: map 1011, capacity 1, best_place 3; repeat exit switch=2: no change, no door.
- Map 1111, switch=1, entry and exit rise in same cycle: map stays 1111 after E2 (slot 1 freed and refilled), door pulses once.
- Entry held high 20 cycles: only one slot taken; door retrigger test: grant at cycle 0 and cycle 2 with DOOR_CYCLES=4 → door high cycles 0–5.
- HALF_100HZ=3, HALF_2HZ=5, HALF_1HZ=10: periods 6/10/20 clk, 50% duty; assert rst_n low mid-run → all outputs 0 immediately.
